// File: rtl/operand_sequencer.sv
// operand_sequencer: steps a combinational two-operand datapath through a
// programmed table of operand pairs, captures each result after a settle
// time, offers it on a valid/ready port and folds it into a rolling signature.
module operand_sequencer #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 8,
  parameter int SETTLE_CYC = 1,
  localparam int IDX_W     = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_we,
  input  logic [IDX_W-1:0] load_addr,
  input  logic [WIDTH-1:0] load_a,
  input  logic [WIDTH-1:0] load_b,
  input  logic [IDX_W:0]   num_vec,
  input  logic             start,
  output logic [WIDTH-1:0] dp_a,
  output logic [WIDTH-1:0] dp_b,
  input  logic [WIDTH-1:0] dp_y,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic [IDX_W-1:0] res_idx,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] signature
);

  localparam int CNT_W = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC + 1);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HOLD,
    DONE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] last;
  logic [IDX_W-1:0] idx_inc;
  logic [IDX_W-1:0] last_init;
  logic [IDX_W:0]   num_clamped;
  logic [CNT_W-1:0] settle_cnt;
  logic             settle_last;
  logic             run_start;
  logic             capture;
  logic             advance;
  logic             handshake;

  logic [WIDTH-1:0] table_a [DEPTH];
  logic [WIDTH-1:0] table_b [DEPTH];

  // State register.
  // NOTE: every clocked process uses non-blocking assignments so all flops
  // sample their inputs from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state decode plus the one-cycle strobes that steer the datapath.
  // NOTE: every output of this block is defaulted first so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_next  = state;
    run_start   = 1'b0;
    capture     = 1'b0;
    advance     = 1'b0;
    settle_last = (settle_cnt == CNT_W'(SETTLE_CYC - 1));
    handshake   = res_valid && res_ready;
    idx_inc     = idx + 1'b1;
    num_clamped = (num_vec > (IDX_W + 1)'(DEPTH)) ? (IDX_W + 1)'(DEPTH) : num_vec;
    last_init   = IDX_W'(num_clamped - 1'b1);
    busy        = (state != IDLE);
    done        = (state == DONE);
    case (state)
      IDLE: begin
        if (start) begin
          if (num_vec != '0) begin
            state_next = SETTLE;
            run_start  = 1'b1;
          end else begin
            state_next = DONE;
          end
        end
      end
      SETTLE: begin
        if (settle_last) begin
          capture    = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (handshake) begin
          if (idx == last) begin
            state_next = DONE;
          end else begin
            advance    = 1'b1;
            state_next = SETTLE;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand table: writable only while idle so a run sees a frozen table.
  // NOTE: the table is reset explicitly because a rerun after reset must
  // return zero results; this keeps it in flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        table_a[i] <= '0;
        table_b[i] <= '0;
      end
    end else if (state == IDLE && load_we) begin
      table_a[load_addr] <= load_a;
      table_b[load_addr] <= load_b;
    end
  end

  // Run datapath: operand drive, settle counter, capture and result port.
  always_ff @(posedge clk) begin
    if (rst) begin
      dp_a       <= '0;
      dp_b       <= '0;
      idx        <= '0;
      last       <= '0;
      settle_cnt <= '0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_idx    <= '0;
      signature  <= '0;
    end else begin
      if (state == IDLE && start) signature <= '0;
      if (run_start) begin
        idx        <= '0;
        last       <= last_init;
        settle_cnt <= '0;
        dp_a       <= table_a[0];
        dp_b       <= table_b[0];
      end
      if (state == SETTLE) begin
        if (capture) begin
          settle_cnt <= '0;
          res_data   <= dp_y;
          res_idx    <= idx;
          res_valid  <= 1'b1;
          signature  <= {signature[WIDTH-2:0], signature[WIDTH-1]} ^ dp_y;
        end else begin
          settle_cnt <= settle_cnt + 1'b1;
        end
      end
      if (state == HOLD && handshake) res_valid <= 1'b0;
      if (advance) begin
        idx  <= idx_inc;
        dp_a <= table_a[idx_inc];
        dp_b <= table_b[idx_inc];
      end
    end
  end

endmodule

// File: tb/tb_operand_sequencer.sv
// Bench for operand_sequencer: models the datapath as dp_y = dp_a | dp_b,
// drives inputs and samples outputs on the falling edge.
module tb_operand_sequencer;

  localparam int WIDTH = 32;
  localparam int DEPTH = 8;
  localparam int IDX_W = 3;

  logic             clk;
  logic             rst;
  logic             load_we;
  logic [IDX_W-1:0] load_addr;
  logic [WIDTH-1:0] load_a;
  logic [WIDTH-1:0] load_b;
  logic [IDX_W:0]   num_vec;
  logic             start;
  logic [WIDTH-1:0] dp_a;
  logic [WIDTH-1:0] dp_b;
  logic [WIDTH-1:0] dp_y;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic [IDX_W-1:0] res_idx;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] signature;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] exp_y;
  } vec_t;

  vec_t vecs [DEPTH];

  operand_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SETTLE_CYC(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .load_we   (load_we),
    .load_addr (load_addr),
    .load_a    (load_a),
    .load_b    (load_b),
    .num_vec   (num_vec),
    .start     (start),
    .dp_a      (dp_a),
    .dp_b      (dp_b),
    .dp_y      (dp_y),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_idx   (res_idx),
    .busy      (busy),
    .done      (done),
    .signature (signature)
  );

  assign dp_y = dp_a | dp_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] sig_model(input int n, input bit cleared);
    logic [WIDTH-1:0] s;
    s = '0;
    for (int i = 0; i < n; i++)
      s = {s[WIDTH-2:0], s[WIDTH-1]} ^ (cleared ? '0 : vecs[i].exp_y);
    return s;
  endfunction

  task automatic pulse_start(input logic [IDX_W:0] n);
    num_vec = n;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  // Accept results from index 'first' up to 'last_excl', checking data, index,
  // that done follows the final handshake by one cycle and lasts one cycle.
  task automatic collect(input string name, input int first, input int last_excl,
                         input bit cleared);
    int got     = first;
    int last_hs = -10;
    bit seen    = 1'b0;
    logic [WIDTH-1:0] exp;
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (done) begin
        check({name, "_done_latency"}, cyc, last_hs + 1);
        seen = 1'b1;
        break;
      end
      if (res_valid && res_ready) begin
        exp = (cleared || got >= DEPTH) ? '0 : vecs[got].exp_y;
        check({name, "_data"}, res_data, exp);
        check({name, "_idx"}, res_idx, got);
        got++;
        last_hs = cyc;
      end
      @(negedge clk);
    end
    check({name, "_done_seen"}, seen, 1);
    check({name, "_count"}, got, last_excl);
    @(negedge clk);
    check({name, "_done_one_cycle"}, done, 0);
    check({name, "_idle_after"}, busy, 0);
  endtask

  initial begin
    bit found;
    vecs[0] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    vecs[1] = '{32'h0000_0001, 32'h0000_1000, 32'h0000_1001};
    vecs[2] = '{32'h1000_0000, 32'h0000_0001, 32'h1000_0001};
    vecs[3] = '{32'hFFFF_0000, 32'h0000_FFFF, 32'hFFFF_FFFF};
    vecs[4] = '{32'hA5A5_A5A5, 32'h5A5A_0000, 32'hFFFF_A5A5};
    vecs[5] = '{32'h8000_0000, 32'h0000_0080, 32'h8000_0080};
    vecs[6] = '{32'h1234_0000, 32'h0000_5678, 32'h1234_5678};
    vecs[7] = '{32'h0F0F_0F0F, 32'h00F0_00F0, 32'h0FFF_0FFF};

    rst = 1'b1; load_we = 1'b0; load_addr = '0; load_a = '0; load_b = '0;
    num_vec = '0; start = 1'b0; res_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_valid", res_valid, 0);
    check("reset_sig", signature, 0);
    check("reset_dp_a", dp_a, 0);
    rst = 1'b0;

    for (int i = 0; i < DEPTH; i++) begin
      load_we = 1'b1; load_addr = IDX_W'(i); load_a = vecs[i].a; load_b = vecs[i].b;
      @(negedge clk);
    end
    load_we = 1'b0;

    // 1: three pairs, ready held high.
    res_ready = 1'b1;
    pulse_start(3);
    check("t1_busy_settle", busy, 1);
    check("t1_valid_settle", res_valid, 0);
    @(negedge clk);
    check("t1_valid_latency", res_valid, 1);
    collect("t1", 0, 3, 1'b0);
    check("t1_signature", signature, 32'h1000_2003);

    // 2: backpressure while pair 1 is held.
    pulse_start(3);
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (res_valid && res_idx == 1) begin found = 1'b1; break; end
      @(negedge clk);
    end
    check("t2_reach_pair1", found, 1);
    res_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("t2_hold_valid", res_valid, 1);
      check("t2_hold_data", res_data, 32'h0000_1001);
      check("t2_hold_dp_a", dp_a, 32'h0000_0001);
      check("t2_hold_dp_b", dp_b, 32'h0000_1000);
    end
    res_ready = 1'b1;
    collect("t2", 1, 3, 1'b0);
    check("t2_signature", signature, 32'h1000_2003);

    // 3: empty run.
    pulse_start(0);
    check("t3_done", done, 1);
    check("t3_valid", res_valid, 0);
    @(negedge clk);
    check("t3_done_off", done, 0);
    check("t3_valid_after", res_valid, 0);
    check("t3_signature", signature, 0);

    // 4: writes and start while busy are ignored; num_vec clamps to DEPTH.
    res_ready = 1'b0;
    pulse_start(15);
    load_we = 1'b1; load_addr = '0; load_a = 32'hDEAD_BEEF; load_b = 32'h0000_0001;
    start = 1'b1; num_vec = 1;
    repeat (2) @(negedge clk);
    load_we = 1'b0; start = 1'b0;
    check("t4_held_idx0", res_idx, 0);
    res_ready = 1'b1;
    collect("t4", 0, DEPTH, 1'b0);
    check("t4_signature", signature, sig_model(DEPTH, 1'b0));
    @(negedge clk);
    check("t4_no_rerun", busy, 0);

    // 5: reset in HOLD clears everything, including the table.
    res_ready = 1'b0;
    pulse_start(3);
    @(negedge clk);
    check("t5_in_hold", res_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_valid", res_valid, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_done", done, 0);
    check("t5_rst_dp_a", dp_a, 0);
    check("t5_rst_dp_b", dp_b, 0);
    check("t5_rst_data", res_data, 0);
    check("t5_rst_idx", res_idx, 0);
    check("t5_rst_sig", signature, 0);
    rst = 1'b0;
    res_ready = 1'b1;
    pulse_start(8);
    @(negedge clk);
    collect("t5", 0, DEPTH, 1'b1);
    check("t5_signature", signature, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
